// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter: round-robin between the ALU and load paths into the single register file
// write port, with a pending-write scoreboard and a committed-write counter.
module rf_wb_arbiter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [4:0]       req0_addr,
  input  logic [31:0]      req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [4:0]       req1_addr,
  input  logic [31:0]      req1_data,
  output logic             req1_ready,
  input  logic             rsv_valid,
  input  logic [4:0]       rsv_addr,
  input  logic [4:0]       chk_a1,
  input  logic [4:0]       chk_a2,
  output logic             busy1,
  output logic             busy2,
  output logic             WE3,
  output logic [4:0]       A3,
  output logic [31:0]      WD3,
  output logic [CNT_W-1:0] wr_count
);

  logic             ptr_q, ptr_d;
  logic             we3_q, we3_d;
  logic [4:0]       a3_q, a3_d;
  logic [31:0]      wd3_q, wd3_d;
  logic [31:0]      sb_q, sb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             accept;
  logic [4:0]       sel_addr;
  logic [31:0]      sel_data;

  // Grants are suppressed during reset so nothing is accepted in that cycle.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (!reset) begin
      req0_ready = req0_valid && (!req1_valid || !ptr_q);
      req1_ready = req1_valid && (!req0_valid || ptr_q);
    end
  end

  assign accept = req0_ready || req1_ready;

  always_comb begin
    sel_addr = req0_addr;
    sel_data = req0_data;
    if (req1_ready) begin
      sel_addr = req1_addr;
      sel_data = req1_data;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (req0_ready) begin
      ptr_d = 1'b1;
    end else if (req1_ready) begin
      ptr_d = 1'b0;
    end
  end

  // Writes to x0 are accepted but never reach the port; A3/WD3 keep their last real write.
  always_comb begin
    we3_d = 1'b0;
    a3_d  = a3_q;
    wd3_d = wd3_q;
    if (accept && (sel_addr != 5'd0)) begin
      we3_d = 1'b1;
      a3_d  = sel_addr;
      wd3_d = sel_data;
    end
  end

  // Clear first, then set, so a fresh reservation survives a same-edge commit.
  always_comb begin
    sb_d = sb_q;
    if (we3_q) begin
      sb_d[a3_q] = 1'b0;
    end
    if (rsv_valid && (rsv_addr != 5'd0)) begin
      sb_d[rsv_addr] = 1'b1;
    end
    sb_d[0] = 1'b0;
  end

  assign cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, we3_q};

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= 1'b0;
      we3_q <= 1'b0;
      a3_q  <= 5'd0;
      wd3_q <= 32'd0;
      sb_q  <= 32'd0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      we3_q <= we3_d;
      a3_q  <= a3_d;
      wd3_q <= wd3_d;
      sb_q  <= sb_d;
      cnt_q <= cnt_d;
    end
  end

  assign busy1    = sb_q[chk_a1];
  assign busy2    = sb_q[chk_a2];
  assign WE3      = we3_q;
  assign A3       = a3_q;
  assign WD3      = wd3_q;
  assign wr_count = cnt_q;

endmodule
